button_debouncer: RTL and testbench
===================================

BUTTON_DEBOUNCER -- requirements
Module: button_debouncer

Interface
REQ-001 SHALL have parameter STABLE_SAMPLES, default 3: the number of consecutive identical samples needed to change the debounced state; the legal range is 2..15.
REQ-002 SHALL have parameter ACTIVE_LOW, default 1: when 1, btn_in=0 means pressed; when 0, btn_in=1 means pressed.
REQ-003 SHALL have port clk, input, 1 bit: the single system clock; all flops are on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port sample_clk, input, 1 bit: the slow sampling square wave from the debounce frequency divider; it is treated as data, never as a clock.
REQ-006 SHALL have port btn_in, input, 1 bit: the raw, asynchronous, bouncing push-button level.
REQ-007 SHALL have port btn_level, output, 1 bit: the debounced level; 1 means pressed, independent of ACTIVE_LOW.
REQ-008 SHALL have port btn_press, output, 1 bit: a one-clk pulse when the debounced state enters pressed.
REQ-009 SHALL have port btn_release, output, 1 bit: a one-clk pulse when the debounced state enters released.

Function
REQ-010 SHALL pass btn_in through a 2-flop synchronizer, then normalize polarity: pressed_s = sync XOR ACTIVE_LOW.
REQ-011 SHALL pass sample_clk through a 2-flop synchronizer plus one history flop, and form sample_tick = s2 AND NOT s3, one clk wide per sample_clk rising edge.
REQ-012 SHALL evaluate the FSM only in cycles where sample_tick=1; between ticks, state, counter and btn_level hold, and btn_in glitches between ticks have no effect.
REQ-013 SHALL implement states RELEASED, PRESS_WAIT, PRESSED and RELEASE_WAIT, with a 4-bit consecutive-sample counter cnt.
REQ-014 In RELEASED on a tick: if pressed_s=1, the FSM SHALL go to PRESS_WAIT with cnt=1; otherwise it SHALL stay in RELEASED with cnt=0.
REQ-015 In PRESS_WAIT on a tick: if pressed_s=0, the FSM SHALL go to RELEASED with cnt=0; if pressed_s=1 and cnt+1==STABLE_SAMPLES, it SHALL go to PRESSED with cnt=0; otherwise cnt SHALL increment.
REQ-016 In PRESSED on a tick: if pressed_s=0, the FSM SHALL go to RELEASE_WAIT with cnt=1; otherwise it SHALL stay in PRESSED.
REQ-017 In RELEASE_WAIT on a tick: if pressed_s=1, the FSM SHALL go to PRESSED with cnt=0; if pressed_s=0 and cnt+1==STABLE_SAMPLES, it SHALL go to RELEASED with cnt=0; otherwise cnt SHALL increment.
REQ-018 btn_level SHALL be 1 exactly when the state is PRESSED or RELEASE_WAIT, registered with the state.
REQ-019 btn_press SHALL be 1 for exactly the one clk cycle in which the state register first holds PRESSED after PRESS_WAIT, i.e. 1 cycle after the qualifying tick.
REQ-020 btn_release SHALL be 1 for exactly the one clk cycle in which the state register first holds RELEASED after RELEASE_WAIT.
REQ-021 Returning to PRESSED from RELEASE_WAIT, or to RELEASED from PRESS_WAIT, SHALL produce no pulse.
REQ-022 btn_press and btn_release SHALL never be high in the same cycle, and btn_level SHALL change only in the cycle of the matching pulse.
REQ-023 Latency from a stable btn_in change SHALL be at most 3 clk cycles plus STABLE_SAMPLES sample periods plus 1 clk cycle.
REQ-024 If sample_clk stops toggling, the FSM SHALL freeze and emit no pulses.

Reset
REQ-025 On reset=1 at a clk edge, the block SHALL load state=RELEASED, cnt=0, btn_level=0, btn_press=0 and btn_release=0.
REQ-026 Reset SHALL load the btn synchronizer flops with the released level (ACTIVE_LOW ? 1 : 0), so that no spurious press occurs.
REQ-027 Reset SHALL load the sample_clk synchronizer and history flops with 1, so that no tick occurs until a genuine 0->1 transition of sample_clk after reset.
REQ-028 Reset SHALL take priority over sample_tick in the same cycle; reset mid-PRESS_WAIT or mid-RELEASE_WAIT SHALL discard partial counts.

Verification (STABLE_SAMPLES=3, ACTIVE_LOW=1, sample_clk 8 clk high / 8 clk low)
REQ-029 Reset with btn_in=1 for 2 cycles, then idle for 200 cycles -> all outputs 0 and no pulses.
REQ-030 btn_in=0 held -> exactly one btn_press pulse 1 cycle after the 3rd tick; btn_level rises in that same cycle; no further pulses while held.
REQ-031 Bounce where the sampled pattern is pressed, released, pressed, pressed, pressed -> a single btn_press after the 5th tick only; btn_in toggling between ticks -> no effect.
REQ-032 From PRESSED, btn_in=1 for 2 ticks then 0 -> no btn_release; btn_in=1 for 3 ticks -> one btn_release pulse and btn_level=0.
REQ-033 Reset after 2 pressed ticks with btn_in held 0 -> btn_press only after 3 fresh ticks after reset.
REQ-034 sample_clk=1 across reset deassertion -> no tick and no cnt change until the next sample_clk rising edge.

Source files
------------

// File: rtl/button_debouncer.sv
// Push-button debouncer: synchronizes the raw button and the divider's sample square wave,
// then requires STABLE_SAMPLES consecutive agreeing samples before the debounced level flips.
//
//   state        | meaning
//   -------------+-----------------------------------------------------------
//   RELEASED     | debounced released, waiting for a first pressed sample
//   PRESS_WAIT   | counting consecutive pressed samples, level still released
//   PRESSED      | debounced pressed, waiting for a first released sample
//   RELEASE_WAIT | counting consecutive released samples, level still pressed
module button_debouncer #(
    parameter int STABLE_SAMPLES = 3,
    parameter bit ACTIVE_LOW     = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic sample_clk,
    input  logic btn_in,
    output logic btn_level,
    output logic btn_press,
    output logic btn_release
);

    typedef enum logic [1:0] {
        ST_RELEASED     = 2'd0,
        ST_PRESS_WAIT   = 2'd1,
        ST_PRESSED      = 2'd2,
        ST_RELEASE_WAIT = 2'd3
    } state_t;

    localparam logic [3:0] LP_TERM = 4'(STABLE_SAMPLES);

    logic       r_btn_s1;
    logic       r_btn_s2;
    logic       r_smp_s1;
    logic       r_smp_s2;
    logic       r_smp_s3;
    state_t     r_state;
    state_t     w_state_nxt;
    logic [3:0] r_cnt;
    logic [3:0] w_cnt_nxt;
    logic [3:0] w_cnt_inc;
    logic       w_pressed;
    logic       w_tick;
    logic       r_level;
    logic       r_press;
    logic       r_release;

    // Sync flops reset to idle values so leaving reset never fakes a press or a tick.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_btn_s1 <= ACTIVE_LOW;
            r_btn_s2 <= ACTIVE_LOW;
            r_smp_s1 <= 1'b1;
            r_smp_s2 <= 1'b1;
            r_smp_s3 <= 1'b1;
        end else begin
            r_btn_s1 <= btn_in;
            r_btn_s2 <= r_btn_s1;
            r_smp_s1 <= sample_clk;
            r_smp_s2 <= r_smp_s1;
            r_smp_s3 <= r_smp_s2;
        end
    end

    assign w_pressed = r_btn_s2 ^ ACTIVE_LOW;
    assign w_tick    = r_smp_s2 & ~r_smp_s3;
    assign w_cnt_inc = r_cnt + 4'd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_RELEASED;
            r_cnt     <= 4'd0;
            r_level   <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_level   <= (w_state_nxt == ST_PRESSED) || (w_state_nxt == ST_RELEASE_WAIT);
            r_press   <= (r_state == ST_PRESS_WAIT) && (w_state_nxt == ST_PRESSED);
            r_release <= (r_state == ST_RELEASE_WAIT) && (w_state_nxt == ST_RELEASED);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (w_tick) begin
            case (r_state)
                ST_RELEASED: begin
                    if (w_pressed) begin
                        w_state_nxt = ST_PRESS_WAIT;
                        w_cnt_nxt   = 4'd1;
                    end else begin
                        w_cnt_nxt   = 4'd0;
                    end
                end
                ST_PRESS_WAIT: begin
                    if (!w_pressed) begin
                        w_state_nxt = ST_RELEASED;
                        w_cnt_nxt   = 4'd0;
                    end else if (w_cnt_inc == LP_TERM) begin
                        w_state_nxt = ST_PRESSED;
                        w_cnt_nxt   = 4'd0;
                    end else begin
                        w_cnt_nxt   = w_cnt_inc;
                    end
                end
                ST_PRESSED: begin
                    if (!w_pressed) begin
                        w_state_nxt = ST_RELEASE_WAIT;
                        w_cnt_nxt   = 4'd1;
                    end
                end
                ST_RELEASE_WAIT: begin
                    if (w_pressed) begin
                        w_state_nxt = ST_PRESSED;
                        w_cnt_nxt   = 4'd0;
                    end else if (w_cnt_inc == LP_TERM) begin
                        w_state_nxt = ST_RELEASED;
                        w_cnt_nxt   = 4'd0;
                    end else begin
                        w_cnt_nxt   = w_cnt_inc;
                    end
                end
                default: begin
                    w_state_nxt = ST_RELEASED;
                    w_cnt_nxt   = 4'd0;
                end
            endcase
        end
    end

    assign btn_level   = r_level;
    assign btn_press   = r_press;
    assign btn_release = r_release;

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer: a sample-level model pushes expected pulses with their
// cycle stamps; a negedge monitor pops them when the DUT pulses and flags extras or misses.
module tb_button_debouncer;

    localparam int STABLE = 3;

    typedef struct {
        bit is_press;
        int cyc;
    } ev_t;

    logic clk = 1'b0;
    logic reset;
    logic sample_clk;
    logic btn_in;
    logic btn_level;
    logic btn_press;
    logic btn_release;

    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    ev_t  sb[$];
    bit   m_level  = 1'b0;
    int   m_run    = 0;

    button_debouncer #(.STABLE_SAMPLES(STABLE), .ACTIVE_LOW(1'b1)) dut (
        .clk         (clk),
        .reset       (reset),
        .sample_clk  (sample_clk),
        .btn_in      (btn_in),
        .btn_level   (btn_level),
        .btn_press   (btn_press),
        .btn_release (btn_release)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Sample-level reference: STABLE consecutive samples disagreeing with the level flip it.
    // A sampled rise at cycle c becomes visible on the outputs at cycle c+3.
    task automatic model_step(input logic b);
        bit p;
        p = ~b;
        if (p != m_level) begin
            m_run++;
            if (m_run == STABLE) begin
                m_level = p;
                m_run   = 0;
                sb.push_back('{is_press: p, cyc: cyc + 3});
            end
        end else begin
            m_run = 0;
        end
    endtask

    // One full sample period (8 high, 8 low); optional btn_in chatter during the low phase.
    task automatic sample(input logic b, input bit glitch);
        @(negedge clk);
        btn_in     = b;
        sample_clk = 1'b1;
        model_step(b);
        repeat (8) @(negedge clk);
        sample_clk = 1'b0;
        repeat (7) begin
            @(negedge clk);
            if (glitch) btn_in = 1'($urandom_range(0, 1));
        end
        chk("level_after_sample", btn_level, m_level);
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        reset = 1'b1;
        repeat (n) @(negedge clk);
        reset   = 1'b0;
        m_level = 1'b0;
        m_run   = 0;
        checks++;
        assert (sb.size() == 0) else begin
            failures++;
            $error("FAIL pending_at_reset observed=%0d expected=0", sb.size());
        end
    endtask

    always @(negedge clk) begin
        if (reset !== 1'b1) begin
            if (btn_press || btn_release) begin
                checks++;
                assert (sb.size() > 0) else begin
                    failures++;
                    $error("FAIL unexpected_pulse observed=press%b/release%b expected=none at cyc=%0d",
                           btn_press, btn_release, cyc);
                end
                if (sb.size() > 0) begin
                    ev_t e;
                    e = sb.pop_front();
                    chk("pulse_press", btn_press, e.is_press);
                    chk("pulse_release", btn_release, ~e.is_press);
                    chk("pulse_level", btn_level, e.is_press);
                    checks++;
                    assert (cyc == e.cyc) else begin
                        failures++;
                        $error("FAIL pulse_cycle observed=%0d expected=%0d", cyc, e.cyc);
                    end
                end
            end else if (sb.size() > 0) begin
                checks++;
                assert (sb[0].cyc >= cyc) else begin
                    failures++;
                    $error("FAIL missed_pulse observed=none expected=%s at cyc=%0d",
                           sb[0].is_press ? "press" : "release", sb[0].cyc);
                    void'(sb.pop_front());
                end
            end
        end
    end

    initial begin
        reset      = 1'b1;
        btn_in     = 1'b1;
        sample_clk = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_level", btn_level, 1'b0);
        chk("rst_press", btn_press, 1'b0);
        chk("rst_release", btn_release, 1'b0);
        repeat (200) @(negedge clk);
        chk("idle_level", btn_level, 1'b0);

        // Clean press, then held pressed
        repeat (3) sample(1'b0, 1'b0);
        repeat (3) sample(1'b0, 1'b0);
        // Short release (2 samples) is rejected, then a genuine release
        sample(1'b1, 1'b0);
        sample(1'b1, 1'b0);
        sample(1'b0, 1'b0);
        repeat (3) sample(1'b1, 1'b0);

        // Bounce pattern pressed, released, pressed x3 with chatter between ticks
        sample(1'b0, 1'b1);
        sample(1'b1, 1'b1);
        sample(1'b0, 1'b1);
        sample(1'b0, 1'b1);
        sample(1'b0, 1'b1);
        repeat (3) sample(1'b1, 1'b1);

        // Reset discards a partial press count
        sample(1'b0, 1'b0);
        sample(1'b0, 1'b0);
        btn_in = 1'b0;
        do_reset(2);
        chk("rst_mid_level", btn_level, 1'b0);
        sample(1'b0, 1'b0);
        sample(1'b0, 1'b0);
        chk("rst_mid_not_yet", btn_level, 1'b0);
        sample(1'b0, 1'b0);
        repeat (3) sample(1'b1, 1'b0);

        // sample_clk high across reset release gives no tick
        btn_in = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        sample_clk = 1'b1;
        repeat (3) @(negedge clk);
        reset   = 1'b0;
        m_level = 1'b0;
        m_run   = 0;
        repeat (8) @(negedge clk);
        sample_clk = 1'b0;
        repeat (7) @(negedge clk);
        chk("hi_rst_level", btn_level, 1'b0);
        sample(1'b0, 1'b0);
        sample(1'b0, 1'b0);
        chk("hi_rst_not_yet", btn_level, 1'b0);
        sample(1'b0, 1'b0);

        // Frozen sample_clk: button activity is ignored
        repeat (100) begin
            @(negedge clk);
            btn_in = 1'($urandom_range(0, 1));
        end
        chk("frozen_level", btn_level, 1'b1);
        repeat (3) sample(1'b1, 1'b0);

        repeat (20) @(negedge clk);
        checks++;
        assert (sb.size() == 0) else begin
            failures++;
            $error("FAIL leftover_events observed=%0d expected=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
